// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch stage, instruction memory, the control
// decoder's redirect and the decode stage.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 32
);
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               redirect_in;
    logic [ADDR_W-1:0]  redirect_target;
    logic               dec_valid;
    logic               dec_ready;
    logic [INSTR_W-1:0] dec_instr_out;
    logic [ADDR_W-1:0]  dec_pc_out;
    logic [1:0]         dec_type_out;
    logic [3:0]         dec_op_out;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_in, redirect_target,
        output dec_valid, dec_instr_out, dec_pc_out, dec_type_out, dec_op_out,
        input  dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_in, redirect_target,
        input  dec_valid, dec_instr_out, dec_pc_out, dec_type_out, dec_op_out,
        output dec_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order imem requests, 2-entry instruction buffer
// towards decode, and flush/restart on a control redirect.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    entry_t            fifo_q [2];
    logic              fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
    logic [1:0]        count_q, count_d;
    logic [1:0]        live_q, live_d;
    logic [1:0]        stale_q, stale_d;
    logic [ADDR_W-1:0] ifq_q [2];
    logic              ifq_rd_q, ifq_rd_d, ifq_wr_q, ifq_wr_d;

    logic   can_issue, accept, rsp_known, rsp_stale, rsp_live, pop;
    entry_t head;

    assign can_issue = (({1'b0, live_q} + {1'b0, count_q}) < 3'd2) &&
                       (({1'b0, live_q} + {1'b0, stale_q}) < 3'd3);

    assign bus.imem_req_valid = rst_n && !bus.redirect_in && can_issue;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign accept             = bus.imem_req_valid && bus.imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_known = bus.imem_rsp_valid && ((stale_q != 2'd0) || (live_q != 2'd0));
    assign rsp_stale = bus.imem_rsp_valid && (stale_q != 2'd0);
    assign rsp_live  = bus.imem_rsp_valid && (stale_q == 2'd0) && (live_q != 2'd0) &&
                       !bus.redirect_in;

    assign bus.dec_valid = (count_q != 2'd0);
    assign pop           = bus.dec_valid && bus.dec_ready && !bus.redirect_in;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        count_d    = count_q;
        live_d     = live_q;
        stale_d    = stale_q;
        ifq_rd_d   = ifq_rd_q;
        ifq_wr_d   = ifq_wr_q;
        if (bus.redirect_in) begin
            fetch_pc_d = bus.redirect_target;
            fifo_rd_d  = 1'b0;
            fifo_wr_d  = 1'b0;
            count_d    = 2'd0;
            live_d     = 2'd0;
            ifq_rd_d   = 1'b0;
            ifq_wr_d   = 1'b0;
            // Any response landing now retires one outstanding request, stale or live.
            stale_d    = stale_q + live_q - {1'b0, rsp_known};
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                ifq_wr_d   = ~ifq_wr_q;
            end
            if (rsp_live) begin
                fifo_wr_d = ~fifo_wr_q;
                ifq_rd_d  = ~ifq_rd_q;
            end
            if (pop) begin
                fifo_rd_d = ~fifo_rd_q;
            end
            if (rsp_stale) begin
                stale_d = stale_q - 2'd1;
            end
            count_d = count_q + {1'b0, rsp_live} - {1'b0, pop};
            live_d  = live_q + {1'b0, accept} - {1'b0, rsp_live};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            fifo_rd_q  <= 1'b0;
            fifo_wr_q  <= 1'b0;
            count_q    <= 2'd0;
            live_q     <= 2'd0;
            stale_q    <= 2'd0;
            ifq_rd_q   <= 1'b0;
            ifq_wr_q   <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            ifq_q[0]   <= '0;
            ifq_q[1]   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            count_q    <= count_d;
            live_q     <= live_d;
            stale_q    <= stale_d;
            ifq_rd_q   <= ifq_rd_d;
            ifq_wr_q   <= ifq_wr_d;
            if (accept) begin
                ifq_q[ifq_wr_q] <= fetch_pc_q;
            end
            if (rsp_live) begin
                fifo_q[fifo_wr_q] <= '{instr: bus.imem_rsp_data, pc: ifq_q[ifq_rd_q]};
            end
        end
    end

    assign head              = fifo_q[fifo_rd_q];
    assign bus.dec_instr_out = bus.dec_valid ? head.instr : '0;
    assign bus.dec_pc_out    = bus.dec_valid ? head.pc : '0;
    assign bus.dec_type_out  = bus.dec_instr_out[INSTR_W-1 -: 2];
    assign bus.dec_op_out    = bus.dec_instr_out[INSTR_W-3 -: 4];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural instruction memory with variable
// latency, plus a scoreboard of expected decode PCs filled at request accept.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(16), .INSTR_W(32)) bus ();

    fetch_unit #(
        .ADDR_W  (16),
        .INSTR_W (32),
        .RESET_PC(16'h0010)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int          due;
        logic [15:0] addr;
    } req_t;

    req_t        pend[$];
    logic [15:0] exp_q[$];
    logic [15:0] exp_addr;
    int          lat, cyc, n_acc, n0, errors, checks;
    logic        found;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (a == 16'h0010) return 32'h4000_0000;
        return {a[1:0], a[5:2], 10'h2a5, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs at the falling edge: request acceptance and decode consumption.
    task automatic sample();
        logic [15:0] e;
        logic [31:0] w;
        if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
            chk("req_addr", 32'(bus.imem_req_addr), 32'(exp_addr));
            exp_q.push_back(exp_addr);
            pend.push_back('{due: cyc + lat, addr: bus.imem_req_addr});
            exp_addr++;
            n_acc++;
        end
        if (rst_n && bus.dec_valid && bus.dec_ready && !bus.redirect_in) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL dec_spurious: observed pc=%0h expected none", bus.dec_pc_out);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                w = mem_word(e);
                chk("dec_pc", 32'(bus.dec_pc_out), 32'(e));
                chk("dec_instr", bus.dec_instr_out, w);
                chk("dec_type", 32'(bus.dec_type_out), 32'(w[31:30]));
                chk("dec_op", 32'(bus.dec_op_out), 32'(w[29:26]));
            end
        end
        if (!bus.dec_valid) begin
            chk("idle_instr", bus.dec_instr_out, 32'h0);
            chk("idle_fields", 32'({bus.dec_pc_out, bus.dec_type_out, bus.dec_op_out}), 32'h0);
        end
    endtask

    // One clock: sample at negedge, memory drives at +1, return at +2.
    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend[0].addr);
            pend.delete(0);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
        #1;
    endtask

    task automatic drain(input string tag);
        bus.imem_req_ready = 1'b0;
        bus.dec_ready      = 1'b1;
        for (int i = 0; i < 40 && (pend.size() != 0 || exp_q.size() != 0 || bus.dec_valid);
             i++) begin
            tick();
        end
        chk({tag, "_left"}, 32'(exp_q.size()), 32'h0);
        chk({tag, "_dec_valid"}, 32'(bus.dec_valid), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0; cyc = 0; n_acc = 0; lat = 1;
        exp_addr               = 16'h0010;
        rst_n                  = 1'b0;
        bus.imem_req_ready     = 1'b1;
        bus.imem_rsp_valid     = 1'b0;
        bus.imem_rsp_data      = '0;
        bus.redirect_in        = 1'b0;
        bus.redirect_target    = '0;
        bus.dec_ready          = 1'b0;

        // Reset values, then start with decode stalled.
        repeat (3) tick();
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_req_addr", 32'(bus.imem_req_addr), 32'h10);
        chk("rst_dec_valid", 32'(bus.dec_valid), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("start_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("start_req_addr", 32'(bus.imem_req_addr), 32'h10);
        tick();
        chk("start_c1_dec_valid", 32'(bus.dec_valid), 32'h0);
        tick();
        chk("start_c2_dec_valid", 32'(bus.dec_valid), 32'h1);
        chk("start_c2_pc", 32'(bus.dec_pc_out), 32'h10);
        chk("start_c2_type", 32'(bus.dec_type_out), 32'h1);
        chk("start_c2_op", 32'(bus.dec_op_out), 32'h0);
        repeat (2) tick();
        chk("bp_accepts", 32'(n_acc), 32'h2);
        chk("bp_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("bp_head_pc", 32'(bus.dec_pc_out), 32'h10);
        bus.dec_ready = 1'b1;
        repeat (12) tick();
        drain("stream");

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3;
        n0  = n_acc;
        bus.imem_req_ready = 1'b1;
        repeat (2) tick();
        chk("rd3_outstanding", 32'(n_acc - n0), 32'h2);
        bus.redirect_in     = 1'b1;
        bus.redirect_target = 16'h0200;
        exp_q.delete();
        exp_addr = 16'h0200;
        #1;
        chk("rd3_no_issue", 32'(bus.imem_req_valid), 32'h0);
        tick();
        bus.redirect_in = 1'b0;
        #1;
        chk("rd3_dec_valid", 32'(bus.dec_valid), 32'h0);
        chk("rd3_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("rd3_req_addr", 32'(bus.imem_req_addr), 32'h200);
        repeat (12) tick();
        drain("rd3");

        // Redirect in the same cycle as a live response and a decode pop.
        lat   = 1;
        found = 1'b0;
        bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = bus.imem_rsp_valid && bus.dec_valid;
        end
        chk("coinc_found", 32'(found), 32'h1);
        bus.redirect_in     = 1'b1;
        bus.redirect_target = 16'h0300;
        exp_q.delete();
        exp_addr = 16'h0300;
        tick();
        bus.redirect_in = 1'b0;
        #1;
        chk("coinc_dec_valid", 32'(bus.dec_valid), 32'h0);
        chk("coinc_req_addr", 32'(bus.imem_req_addr), 32'h300);
        repeat (12) tick();
        drain("coinc");

        // PC wrap.
        bus.imem_req_ready  = 1'b1;
        bus.redirect_in     = 1'b1;
        bus.redirect_target = 16'hffff;
        exp_q.delete();
        exp_addr = 16'hffff;
        tick();
        bus.redirect_in = 1'b0;
        #1;
        chk("wrap_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("wrap_req_addr", 32'(bus.imem_req_addr), 32'hffff);
        repeat (10) tick();
        drain("wrap");

        // Reset with two requests outstanding; their late responses must vanish.
        lat = 3;
        n0  = n_acc;
        bus.imem_req_ready = 1'b1;
        repeat (2) tick();
        bus.imem_req_ready = 1'b0;
        chk("mrst_outstanding", 32'(n_acc - n0), 32'h2);
        rst_n = 1'b0;
        exp_q.delete();
        exp_addr = 16'h0010;
        #1;
        chk("mrst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("mrst_req_addr", 32'(bus.imem_req_addr), 32'h10);
        chk("mrst_dec_valid", 32'(bus.dec_valid), 32'h0);
        chk("mrst_dec_pc", 32'(bus.dec_pc_out), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_late_dec_valid", 32'(bus.dec_valid), 32'h0);
            chk("mrst_restart_addr", 32'(bus.imem_req_addr), 32'h10);
        end
        lat = 1;
        bus.imem_req_ready = 1'b1;
        repeat (8) tick();
        drain("mrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
